// File: rtl/radix4_booth_operand_seq.sv
// Radix-4 Booth operand front-end: captures X/Y, holds X multiples, and
// streams one selected partial product (plus negation carry) per Y digit.
module radix4_booth_operand_seq #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1,
    localparam int PPW   = WIDTH + 2,
    localparam int YE    = (SIGNED != 0) ? ((WIDTH + 1) / 2) * 2 : ((WIDTH + 2) / 2) * 2,
    localparam int NDIG  = YE / 2,
    localparam int IDXW  = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic            abort,
    output logic            pp_valid,
    input  logic            pp_ready,
    output logic [PPW-1:0]  pp,
    output logic            pp_cin,
    output logic [IDXW-1:0] digit_idx,
    output logic            digit_last,
    output logic            done
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [YE:0]     ye_q, ye_d;          // extended Y with the implicit y[-1]=0 at bit 0
    logic [PPW-1:0]  mx_q, mx_d;
    logic [PPW-1:0]  mxn_q, mxn_d;
    logic [PPW-1:0]  m2x_q, m2x_d;
    logic [PPW-1:0]  m2xn_q, m2xn_d;
    logic [PPW-1:0]  pp_q, pp_d;
    logic            pp_cin_q, pp_cin_d;

    logic [PPW-1:0]  xe;
    logic [YE-1:0]   ye_ext;
    logic            sx, sy;
    logic [2:0]      trip;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            ye_q     <= '0;
            mx_q     <= '0;
            mxn_q    <= '0;
            m2x_q    <= '0;
            m2xn_q   <= '0;
            pp_q     <= '0;
            pp_cin_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ye_q     <= ye_d;
            mx_q     <= mx_d;
            mxn_q    <= mxn_d;
            m2x_q    <= m2x_d;
            m2xn_q   <= m2xn_d;
            pp_q     <= pp_d;
            pp_cin_q <= pp_cin_d;
        end
    end

    // Next-state logic; the selected digit is computed from the next index so
    // pp/pp_cin are registered and line up with digit_idx.
    always_comb begin
        sx     = (SIGNED != 0) & x[WIDTH-1];
        sy     = (SIGNED != 0) & y[WIDTH-1];
        xe     = {{2{sx}}, x};
        ye_ext = YE'({{2{sy}}, y});

        state_d = state_q;
        idx_d   = idx_q;
        ye_d    = ye_q;
        mx_d    = mx_q;
        mxn_d   = mxn_q;
        m2x_d   = m2x_q;
        m2xn_d  = m2xn_q;

        case (state_q)
            S_IDLE: begin
                if (!abort && in_valid) begin
                    ye_d    = {ye_ext, 1'b0};
                    mx_d    = xe;
                    mxn_d   = ~xe;
                    m2x_d   = {xe[PPW-2:0], 1'b0};
                    m2xn_d  = ~{xe[PPW-2:0], 1'b0};
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pp_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        trip = 3'b000;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_d == IDXW'(i)) begin
                trip = ye_d[2*i +: 3];
            end
        end

        pp_d     = '0;
        pp_cin_d = 1'b0;
        case (trip)
            3'b001, 3'b010: pp_d = mx_d;
            3'b011:         pp_d = m2x_d;
            3'b100: begin
                pp_d     = m2xn_d;
                pp_cin_d = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_d     = mxn_d;
                pp_cin_d = 1'b1;
            end
            default: begin
                pp_d     = '0;
                pp_cin_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready   = (state_q == S_IDLE);
        pp_valid   = (state_q == S_RUN);
        done       = (state_q == S_DONE);
        digit_idx  = idx_q;
        digit_last = (state_q == S_RUN) && (idx_q == LAST_IDX);
        pp         = pp_q;
        pp_cin     = pp_cin_q;
    end

endmodule
